bht_access_arbiter: RTL

//  Shares the single-port BHT between fetch-stage lookups and execute-stage counter updates.

---
 rtl/bht_access_arbiter_if.sv | 52 +++++
 rtl/bht_access_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/bht_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// bht_access_arbiter_if
//   Bundles the fetch lookup channel, the execute update channel, the BHT
//   array port and the arbiter status outputs.
//   Modports:
//     slave  - arbiter view (the bht_access_arbiter itself)
//     master - surrounding pipeline / BHT array view
//   Signals:
//     lk_valid/lk_ready/lk_pc          lookup request handshake
//     lk_rsp_valid/lk_rsp_ctr          lookup response, one cycle after accept
//     up_valid/up_ready/up_pc/up_ctr/up_taken  counter update handshake
//     bht_en/bht_we/bht_idx/bht_wdata  single-port BHT access
//     bht_rdata                        BHT read data, cycle after a read
//     q_count/draining                 queue occupancy and forced-drain flag
// ---------------------------------------------------------------------------
interface bht_access_arbiter_if #(
    parameter int IDX_W     = 8,
    parameter int UPD_DEPTH = 4
);
    logic                         lk_valid;
    logic                         lk_ready;
    logic [31:0]                  lk_pc;
    logic                         lk_rsp_valid;
    logic [1:0]                   lk_rsp_ctr;

    logic                         up_valid;
    logic                         up_ready;
    logic [31:0]                  up_pc;
    logic [1:0]                   up_ctr;
    logic                         up_taken;

    logic                         bht_en;
    logic                         bht_we;
    logic [IDX_W-1:0]             bht_idx;
    logic [1:0]                   bht_wdata;
    logic [1:0]                   bht_rdata;

    logic [$clog2(UPD_DEPTH):0]   q_count;
    logic                         draining;

    modport slave (
        input  lk_valid, lk_pc, up_valid, up_pc, up_ctr, up_taken, bht_rdata,
        output lk_ready, lk_rsp_valid, lk_rsp_ctr, up_ready,
               bht_en, bht_we, bht_idx, bht_wdata, q_count, draining
    );

    modport master (
        output lk_valid, lk_pc, up_valid, up_pc, up_ctr, up_taken, bht_rdata,
        input  lk_ready, lk_rsp_valid, lk_rsp_ctr, up_ready,
               bht_en, bht_we, bht_idx, bht_wdata, q_count, draining
    );
endinterface

// File: rtl/bht_access_arbiter.sv
// ---------------------------------------------------------------------------
// bht_access_arbiter
//   Shares a single-port BHT between fetch lookups and execute-stage counter
//   updates. Lookups win; updates are saturated at push time, parked in a
//   small FIFO and written back in idle slots. A starvation guard forces a
//   drain phase (fetch stalled) when the FIFO fills or the head update has
//   waited STARVE_LIMIT cycles.
//   Ports:
//     clk_i  - clock, rising edge
//     rst_ni - asynchronous active-low reset
//     bus    - bht_access_arbiter_if.slave (lookup, update, BHT, status)
//   Optional feature macro: BHT_QUEUE_FWD_EN
//     defined   - a lookup hitting a queued update returns the youngest
//                 queued counter instead of the (stale) BHT read data
//     undefined - lookup response is always the BHT read data
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_RUN   | lookups accepted; queued updates drain in lookup-free cycles
//   ST_DRAIN | fetch stalled; one queued update written per cycle until empty
// ---------------------------------------------------------------------------
module bht_access_arbiter #(
    parameter int IDX_W        = 8,
    parameter int UPD_DEPTH    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    bht_access_arbiter_if.slave  bus
);
    localparam int PW = $clog2(UPD_DEPTH);
    localparam int AW = $clog2(STARVE_LIMIT + 1);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    localparam logic [PW:0]   FULL_CNT = (PW+1)'(UPD_DEPTH);
    localparam logic [AW-1:0] AGE_MAX  = AW'(STARVE_LIMIT);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [1:0]       ctr;
    } upd_t;

    upd_t             fifo_q [UPD_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q, count_d;
    logic [AW-1:0]    age_q, age_d;
    logic [0:0]       state_q, state_d;
    logic             rsp_valid_q;

    logic             lk_acc, push, pop;
    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [1:0]       new_ctr;
    upd_t             head;

    assign lk_idx = bus.lk_pc[IDX_W+1:2];
    assign up_idx = bus.up_pc[IDX_W+1:2];
    assign head   = fifo_q[rd_ptr_q];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.lk_pc[31:IDX_W+2], bus.lk_pc[1:0],
                              bus.up_pc[31:IDX_W+2], bus.up_pc[1:0]};

    // Saturating 2-bit counter step, done once at push so the drain path is a plain copy.
    always_comb begin
        new_ctr = bus.up_ctr;
        if (bus.up_taken) begin
            if (bus.up_ctr != 2'd3) new_ctr = bus.up_ctr + 2'd1;
        end else begin
            if (bus.up_ctr != 2'd0) new_ctr = bus.up_ctr - 2'd1;
        end
    end

    assign bus.lk_ready = (state_q == ST_RUN);
    assign bus.up_ready = (count_q != FULL_CNT);
    assign bus.draining = (state_q == ST_DRAIN);
    assign bus.q_count  = count_q;

    assign lk_acc = bus.lk_valid & bus.lk_ready;
    assign push   = bus.up_valid & bus.up_ready;
    // lk_acc is never set in DRAIN, so this also covers the drain-every-cycle case.
    assign pop    = (count_q != '0) & ~lk_acc;

    assign bus.bht_en    = lk_acc | pop;
    assign bus.bht_we    = pop;
    assign bus.bht_idx   = lk_acc ? lk_idx : head.idx;
    assign bus.bht_wdata = pop ? head.ctr : 2'b00;

    assign count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);

    always_comb begin
        age_d = '0;
        if ((count_q != '0) && !pop) begin
            age_d = (age_q == AGE_MAX) ? age_q : age_q + AW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if ((count_d == FULL_CNT) || (age_d == AGE_MAX)) state_d = ST_DRAIN;
            ST_DRAIN: if (count_d == '0) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            age_q       <= '0;
            state_q     <= ST_RUN;
            rsp_valid_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q     <= count_d;
            age_q       <= age_d;
            state_q     <= state_d;
            rsp_valid_q <= lk_acc;
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= '{idx: up_idx, ctr: new_ctr};
    end

`ifdef BHT_QUEUE_FWD_EN
    logic       fwd_hit, fwd_hit_q;
    logic [1:0] fwd_ctr, fwd_ctr_q;

    // Scan stored entries oldest to youngest so the youngest match wins.
    // A push in the same cycle is not yet stored and is not considered.
    always_comb begin
        fwd_hit = 1'b0;
        fwd_ctr = 2'b00;
        for (int i = 0; i < UPD_DEPTH; i++) begin
            if (((PW+1)'(i) < count_q) &&
                (fifo_q[rd_ptr_q + PW'(i)].idx == lk_idx)) begin
                fwd_hit = 1'b1;
                fwd_ctr = fifo_q[rd_ptr_q + PW'(i)].ctr;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fwd_hit_q <= 1'b0;
            fwd_ctr_q <= 2'b00;
        end else begin
            fwd_hit_q <= lk_acc & fwd_hit;
            fwd_ctr_q <= fwd_ctr;
        end
    end

    assign bus.lk_rsp_ctr = !rsp_valid_q ? 2'b00 :
                            (fwd_hit_q ? fwd_ctr_q : bus.bht_rdata);
`else
    assign bus.lk_rsp_ctr = rsp_valid_q ? bus.bht_rdata : 2'b00;
`endif

    assign bus.lk_rsp_valid = rsp_valid_q;
endmodule
